impact_sram_io_ctrl: RTL



---
 rtl/impact_sram_io_ctrl.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/impact_sram_io_ctrl.sv
// Pad-side command front end for the IMPACT SRAM banks.
// Optional write-data truncation is enabled by defining IMPACT_TRUNC_EN.
module impact_sram_io_ctrl #(
  parameter int READ_LAT    = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   data_in,
  input  logic [9:0]   word_select,
  input  logic [1:0]   bank_select,
  input  logic [1:0]   byte_select,
  input  logic         write_enable,
  input  logic         read_enable,
  input  logic [3:0]   trunc_select,
  output logic [3:0]   sram_csb,
  output logic         sram_web,
  output logic [3:0]   sram_wmask,
  output logic [9:0]   sram_addr,
  output logic [31:0]  sram_din,
  input  logic [127:0] sram_dout,
  output logic [7:0]   data_out,
  output logic [37:0]  io_oeb,
  output logic         busy,
  output logic [7:0]   overrun_cnt
);

  typedef enum logic [2:0] {
    IDLE, WRITE, READ, RWAIT, DONE
  } state_e;

  localparam int PW = 28;
  localparam logic [1:0] RLAST = 2'(READ_LAT - 1);

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0][PW-1:0] sync_q;
  logic [PW-1:0] pad_w, s_w;
  logic          s_we, s_re, s_we_d_q, s_re_d_q;
  logic          we_rise, re_rise;
  logic [7:0]    s_data;
  logic [9:0]    s_word;
  logic [1:0]    s_bank, s_byte;
  logic [3:0]    s_trunc;
  logic [7:0]    wbyte;

  logic [9:0]  addr_q, addr_d;
  logic [31:0] din_q, din_d;
  logic [3:0]  wmask_q, wmask_d;
  logic [1:0]  bank_q, bank_d;
  logic [1:0]  byte_q, byte_d;
  logic [7:0]  dout_q, dout_d;
  logic [7:0]  ovr_q, ovr_d;
  logic [1:0]  rcnt_q, rcnt_d;
  logic        drop;
  logic [6:0]  rsel;

  assign pad_w = {trunc_select, data_in, word_select,
                  bank_select, byte_select,
                  read_enable, write_enable};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= pad_w;
      for (int i = 1; i < SYNC_STAGES; i++)
        sync_q[i] <= sync_q[i-1];
    end
  end

  assign s_w = sync_q[SYNC_STAGES-1];
  assign {s_trunc, s_data, s_word, s_bank, s_byte, s_re, s_we} = s_w;

  assign we_rise = s_we & ~s_we_d_q;
  assign re_rise = s_re & ~s_re_d_q;

`ifdef IMPACT_TRUNC_EN
  // trunc_select >= 8 clears the whole byte
  assign wbyte = s_trunc[3] ? 8'h00
               : (s_data & (8'hFF << s_trunc[2:0]));
`else
  assign wbyte = s_data;
`endif

  assign rsel = {bank_q, byte_q, 3'b000};

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    din_d   = din_q;
    wmask_d = wmask_q;
    bank_d  = bank_q;
    byte_d  = byte_q;
    dout_d  = dout_q;
    rcnt_d  = rcnt_q;
    drop    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (we_rise && re_rise) begin
          drop = 1'b1;
        end else if (we_rise) begin
          addr_d  = s_word;
          bank_d  = s_bank;
          byte_d  = s_byte;
          din_d   = {4{wbyte}};
          wmask_d = 4'b0001 << s_byte;
          state_d = WRITE;
        end else if (re_rise) begin
          addr_d  = s_word;
          bank_d  = s_bank;
          byte_d  = s_byte;
          state_d = READ;
        end
      end
      WRITE: state_d = DONE;
      READ: begin
        rcnt_d  = 2'd0;
        state_d = RWAIT;
      end
      RWAIT: begin
        if (rcnt_q == RLAST) begin
          dout_d  = sram_dout[rsel +: 8];
          state_d = DONE;
        end else begin
          rcnt_d = rcnt_q + 2'd1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state_q != IDLE && (we_rise || re_rise))
      drop = 1'b1;
    ovr_d = (drop && ovr_q != 8'hFF) ? ovr_q + 8'd1 : ovr_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      s_we_d_q <= 1'b0;
      s_re_d_q <= 1'b0;
      addr_q   <= '0;
      din_q    <= '0;
      wmask_q  <= '0;
      bank_q   <= '0;
      byte_q   <= '0;
      dout_q   <= '0;
      ovr_q    <= '0;
      rcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      s_we_d_q <= s_we;
      s_re_d_q <= s_re;
      addr_q   <= addr_d;
      din_q    <= din_d;
      wmask_q  <= wmask_d;
      bank_q   <= bank_d;
      byte_q   <= byte_d;
      dout_q   <= dout_d;
      ovr_q    <= ovr_d;
      rcnt_q   <= rcnt_d;
    end
  end

  // Strobes decode from the async-reset state so reset releases csb at once
  always_comb begin
    sram_csb = 4'hF;
    sram_web = 1'b1;
    if (state_q == WRITE) begin
      sram_csb[bank_q] = 1'b0;
      sram_web         = 1'b0;
    end else if (state_q == READ) begin
      sram_csb[bank_q] = 1'b0;
    end
  end

  assign sram_wmask  = wmask_q;
  assign sram_addr   = addr_q;
  assign sram_din    = din_q;
  assign data_out    = dout_q;
  assign busy        = (state_q != IDLE);
  assign overrun_cnt = ovr_q;
  assign io_oeb      = {22'h3FFFFF, 8'h00, 8'hFF};

endmodule
